// File: rtl/line_writeback_serializer.sv
// line_writeback_serializer
//
// Takes one cache line (WORDS_PER_LINE words of WORD_BITS) with its byte
// strobes and emits it as WORDS_PER_LINE write beats. The beats come out in
// wrap order: the first beat is the word at start_offset, and the word index
// wraps from the top word back to word 0.
//
// Ports
//   clk, rst      : single clock; synchronous active-high reset
//   line_valid    : a line is offered (accepted only while line_ready=1)
//   line_ready    : serializer is idle and can accept a line
//   line_data     : line payload, word k = bits [WORD_BITS*k +: WORD_BITS]
//   line_strb     : byte strobes, word k = bits [(WORD_BITS/8)*k +: WORD_BITS/8]
//   line_addr     : line address; the byte-within-line bits are ignored
//   start_offset  : word index of the first beat
//   beat_valid    : a beat is presented
//   beat_ready    : memory accepts the beat
//   beat_data     : beat payload
//   beat_strb     : beat byte enables (zero-strobe beats are still issued)
//   beat_addr     : byte address of the beat's word
//   beat_last     : final beat of the line
//   busy          : a line is held and not yet fully sent
//   dbg_state     : FSM state, 0 = IDLE, 1 = SEND
//
// Handshakes: each side transfers on the rising edge where valid and ready
// are both high. Once beat_valid rises it stays high, with beat_* held
// stable, until that beat transfers. line_ready never depends
// combinationally on line_valid, and beat_* never depend on beat_ready.

module line_writeback_serializer #(
    parameter int WORD_BITS      = 32,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                line_valid,
    output logic                                line_ready,
    input  logic [WORD_BITS*WORDS_PER_LINE-1:0] line_data,
    input  logic [WORDS_PER_LINE*WORD_BITS/8-1:0] line_strb,
    input  logic [31:0]                         line_addr,
    input  logic [$clog2(WORDS_PER_LINE)-1:0]   start_offset,
    output logic                                beat_valid,
    input  logic                                beat_ready,
    output logic [WORD_BITS-1:0]                beat_data,
    output logic [WORD_BITS/8-1:0]              beat_strb,
    output logic [31:0]                         beat_addr,
    output logic                                beat_last,
    output logic                                busy,
    output logic                                dbg_state
);

    localparam int LINE_BITS = WORD_BITS * WORDS_PER_LINE;
    localparam int STRB_BITS = WORD_BITS / 8;
    localparam int IDX_W     = $clog2(WORDS_PER_LINE);
    localparam int BYTE_W    = $clog2(STRB_BITS);
    localparam int OFF_W     = IDX_W + BYTE_W;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                            state;
    logic [IDX_W-1:0]                  cnt;
    logic [IDX_W-1:0]                  offset_q;
    logic [LINE_BITS-1:0]              data_q;
    logic [WORDS_PER_LINE*STRB_BITS-1:0] strb_q;
    logic [31-OFF_W:0]                 addr_q;
    logic [IDX_W-1:0]                  idx;

    // Byte-within-line address bits are deliberately not stored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^line_addr[OFF_W-1:0];

    // Word counts are a power of two, so the natural wrap of the IDX_W-bit
    // sum gives the required modulo.
    assign idx = offset_q + cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            offset_q <= '0;
            data_q   <= '0;
            strb_q   <= '0;
            addr_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (line_valid) begin
                        data_q   <= line_data;
                        strb_q   <= line_strb;
                        addr_q   <= line_addr[31:OFF_W];
                        offset_q <= start_offset;
                        cnt      <= '0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (beat_ready) begin
                        if (cnt == IDX_W'(WORDS_PER_LINE - 1)) begin
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Both handshake outputs are forced low while reset is held so nothing
    // is accepted or presented across a reset edge.
    assign line_ready = (state == IDLE) && !rst;
    assign beat_valid = (state == SEND) && !rst;
    assign busy       = (state == SEND);
    assign dbg_state  = (state == SEND);
    assign beat_last  = (state == SEND) && (cnt == IDX_W'(WORDS_PER_LINE - 1));
    assign beat_data  = data_q[WORD_BITS*idx +: WORD_BITS];
    assign beat_strb  = strb_q[STRB_BITS*idx +: STRB_BITS];
    assign beat_addr  = {addr_q, idx, {BYTE_W{1'b0}}};

endmodule

// File: tb/tb_line_writeback_serializer.sv
module tb_line_writeback_serializer;

  // beat record: {data[31:0], strb[3:0], addr[31:0], last}
  localparam int REC_W = 69;

  logic         clk = 1'b0;
  logic         rst;
  logic         line_valid;
  logic         line_ready;
  logic [127:0] line_data;
  logic [15:0]  line_strb;
  logic [31:0]  line_addr;
  logic [1:0]   start_offset;
  logic         beat_valid;
  logic         beat_ready;
  logic [31:0]  beat_data;
  logic [3:0]   beat_strb;
  logic [31:0]  beat_addr;
  logic         beat_last;
  logic         busy;
  logic         dbg_state;

  line_writeback_serializer #(
    .WORD_BITS      (32),
    .WORDS_PER_LINE (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .line_valid   (line_valid),
    .line_ready   (line_ready),
    .line_data    (line_data),
    .line_strb    (line_strb),
    .line_addr    (line_addr),
    .start_offset (start_offset),
    .beat_valid   (beat_valid),
    .beat_ready   (beat_ready),
    .beat_data    (beat_data),
    .beat_strb    (beat_strb),
    .beat_addr    (beat_addr),
    .beat_last    (beat_last),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int xfers  = 0;
  logic [REC_W-1:0] exp_q[$];
  logic             hold_pend = 1'b0;
  logic [REC_W-1:0] hold_val;

  task automatic check(input string tag, input logic [REC_W-1:0] obs,
                       input logic [REC_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected beats of one line, in wrap order.
  task automatic push_line(input logic [127:0] d, input logic [15:0] s,
                           input logic [31:0] a, input logic [1:0] off);
    logic [1:0]  w;
    logic [31:0] wa;
    for (int c = 0; c < 4; c++) begin
      w  = off + 2'(c);
      wa = {a[31:4], w, 2'b00};
      exp_q.push_back({d[32*w +: 32], s[4*w +: 4], wa, (c == 3)});
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [REC_W-1:0] cur;
    logic [REC_W-1:0] e;
    if (!rst && beat_valid) begin
      cur = {beat_data, beat_strb, beat_addr, beat_last};
      if (hold_pend) check("stable_under_stall", cur, hold_val);
      if (beat_ready) begin
        if (exp_q.size() == 0) begin
          check("beat_extra_queue_size", REC_W'(exp_q.size()), REC_W'(1));
        end else begin
          e = exp_q.pop_front();
          check("beat", cur, e);
        end
        xfers++;
        hold_pend = 1'b0;
      end else begin
        hold_pend = 1'b1;
        hold_val  = cur;
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Offers one line starting just after a rising edge; returns #1 after the
  // accepting edge with line_valid dropped.
  task automatic send_line(input logic [127:0] d, input logic [15:0] s,
                           input logic [31:0] a, input logic [1:0] off);
    @(posedge clk);
    #1;
    line_valid   = 1'b1;
    line_data    = d;
    line_strb    = s;
    line_addr    = a;
    start_offset = off;
    push_line(d, s, a, off);
    @(negedge clk);
    check("ready_before_accept", REC_W'(line_ready), REC_W'(1));
    @(posedge clk);
    #1;
    line_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (line_ready && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check(tag, REC_W'(done), REC_W'(1));
  endtask

  // ---------------- directed sequence ----------------
  logic [127:0] base_line;
  logic [7:0]   pat;
  int           xb;

  initial begin
    base_line    = 128'h44444444_33333333_22222222_11111111;
    rst          = 1'b1;
    line_valid   = 1'b0;
    line_data    = '0;
    line_strb    = '0;
    line_addr    = '0;
    start_offset = '0;
    beat_ready   = 1'b1;

    // reset behaviour
    @(negedge clk);
    check("rst_line_ready", REC_W'(line_ready), REC_W'(0));
    check("rst_beat_valid", REC_W'(beat_valid), REC_W'(0));
    @(negedge clk);
    check("rst_outputs",
          REC_W'({beat_valid, beat_last, busy, beat_data, beat_strb, beat_addr}),
          REC_W'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", REC_W'(line_ready), REC_W'(1));

    // basic, offset 0, with cycle-accurate timing
    xb = xfers;
    send_line(base_line, 16'hFFFF, 32'h0000_1230, 2'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("send_busy", REC_W'({busy, line_ready, beat_valid}), REC_W'(3'b101));
    end
    @(negedge clk);
    check("ready_at_n_plus_5", REC_W'({line_ready, busy, beat_valid}), REC_W'(3'b100));
    wait_idle("basic_done");
    check("basic_count", REC_W'(xfers - xb), REC_W'(4));

    // wrap-around from word 2
    xb = xfers;
    send_line(base_line, 16'hFFFF, 32'h0000_1230, 2'd2);
    wait_idle("wrap_done");
    check("wrap_count", REC_W'(xfers - xb), REC_W'(4));

    // partial strobe, including two zero-strobe beats; low addr bits ignored
    xb = xfers;
    send_line(base_line, 16'h0F30, 32'h0000_123F, 2'd0);
    wait_idle("strb_done");
    check("strb_count", REC_W'(xfers - xb), REC_W'(4));

    // backpressure: beat_ready pattern 0,0,1,0,1,1,0,1
    xb  = xfers;
    pat = 8'b1011_0100;
    beat_ready = 1'b0;
    send_line({$urandom, $urandom, $urandom, $urandom}, 16'hA5C3,
              32'h8000_0040, 2'd1);
    for (int i = 0; i < 8; i++) begin
      beat_ready = pat[i];
      @(negedge clk);
      check("bp_line_ready_low", REC_W'(line_ready), REC_W'(0));
      @(posedge clk);
      #1;
    end
    beat_ready = 1'b1;
    wait_idle("bp_done");
    check("bp_count", REC_W'(xfers - xb), REC_W'(4));

    // input changes during SEND must not disturb the line in flight
    xb = xfers;
    send_line(128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001, 16'h1248,
              32'h0000_5550, 2'd3);
    beat_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      line_valid   = 1'b1;
      line_data    = {$urandom, $urandom, $urandom, $urandom};
      line_strb    = 16'($urandom_range(0, 65535));
      line_addr    = $urandom;
      start_offset = 2'($urandom_range(0, 3));
      @(posedge clk);
      #1;
    end
    line_valid = 1'b0;
    beat_ready = 1'b1;
    wait_idle("inchg_done");
    check("inchg_count", REC_W'(xfers - xb), REC_W'(4));

    // reset after two beats: remaining beats are dropped
    xb = xfers;
    send_line(128'h0BAD0004_0BAD0003_0BAD0002_0BAD0001, 16'hFFFF,
              32'h0000_9990, 2'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid_during_rst", REC_W'(beat_valid), REC_W'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_two_beats", REC_W'(xfers - xb), REC_W'(2));
    exp_q.delete();
    @(negedge clk);
    check("midrst_valid_after", REC_W'({beat_valid, busy}), REC_W'(0));
    repeat (4) @(negedge clk);
    check("midrst_no_more_beats", REC_W'(xfers - xb), REC_W'(2));

    // a fresh line after reset
    xb = xfers;
    send_line({$urandom, $urandom, $urandom, $urandom}, 16'h7E81,
              32'h1234_5670, 2'd1);
    wait_idle("post_rst_done");
    check("post_rst_count", REC_W'(xfers - xb), REC_W'(4));

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_writeback_serializer.md
# line_writeback_serializer

Unpacks one 128-bit cache line plus its 16-bit byte strobe into four sequential 32-bit write beats with per-beat byte enables and addresses. It is the inverse of the processor-side line/strobe packer. It sits between the data cache's write-back/flush path and the memory write port. Beats are issued in wrap order, starting at a requested word offset.

## Interface
Parameters
- WORD_BITS, 32, beat data width (matches `WORD)
- WORDS_PER_LINE, 4, beats per line; line width = WORD_BITS*WORDS_PER_LINE (matches `CACHE_LINE_BIT_LENGTH)

Ports
- clk  input  1  single clock; all state on rising edge
- rst  input  1  reset, synchronous and active-high
- line_valid  input  1  a line is offered
- line_ready  output  1  serializer can accept a line
- line_data  input  128  line payload; word k = bits [32k+31:32k]
- line_strb  input  16  byte strobes; bits [4k+3:4k] belong to word k
- line_addr  input  32  line address; bits [3:0] ignored
- start_offset  input  2  word index of first beat
- beat_valid  output  1  beat present
- beat_ready  input  1  memory accepts beat
- beat_data  output  32  beat payload
- beat_strb  output  4  beat byte enables
- beat_addr  output  32  word address of beat
- beat_last  output  1  final beat of the line
- busy  output  1  line held and not yet fully sent

## Operation
- Two-state FSM: IDLE, SEND.
- IDLE:
  - line_ready=1, beat_valid=0.
  - On line_valid: register line_data, line_strb, line_addr[31:4] and start_offset; clear beat counter cnt (2 bits); go to SEND.
- SEND:
  - line_ready=0, beat_valid=1, busy=1.
  - Word index idx = (start_offset_q + cnt) mod 4, wrapping 3 to 0.
  - beat_data = data_q[32*idx +: 32]; beat_strb = strb_q[4*idx +: 4].
  - beat_addr = {addr_q[31:4], idx, 2'b00}.
  - beat_last = (cnt == 3).
- Handshake: a beat transfers on beat_valid & beat_ready.
  - Non-last beat: cnt increments.
  - Last beat: return to IDLE.
- While beat_ready=0, all beat_* outputs stay stable; valid is never withdrawn.
- Beats whose strobe is 4'h0 are still issued, with beat_strb=0 and data passed unmasked. The beat count is always exactly 4.
- line_* inputs are ignored outside the IDLE acceptance cycle. Input changes during SEND do not affect the line in flight.
- beat_data, beat_strb and beat_addr are don't-care when beat_valid=0. The bench must not check them then.

## Timing
- Reset (rst=1 at an edge):
  - state becomes IDLE; cnt, data_q, strb_q, addr_q and offset_q are cleared.
  - While rst is asserted, line_ready=0 and beat_valid=0.
  - Outputs after the reset edge: beat_valid=0, beat_last=0, busy=0, beat_data=0, beat_strb=0, beat_addr=0.
  - line_ready=1 in the first cycle after rst deasserts.
- Reset mid-line: the in-flight line is dropped with no further beats. beat_valid falls in the cycle after the reset edge.
- Latency: line accepted at edge N gives beat_valid=1 from cycle N+1, with beat 0 presented.
- Throughput: with beat_ready held at 1, beats transfer at edges N+1 through N+4. line_ready returns in cycle N+5. Minimum line period is 5 cycles; no same-cycle accept on the last beat.
- Outputs are combinational from registered state only. There is no combinational path from beat_ready to beat_* or from line_valid to line_ready.

## Test plan
- Basic, offset 0:
  - Stimulus: line_data=128'h44444444_33333333_22222222_11111111, strb=16'hFFFF, addr=32'h0000_1230, beat_ready=1.
  - Required: beats 11111111@0x1230, 22222222@0x1234, 33333333@0x1238, 44444444@0x123C; strb F each; beat_last only on the 4th; line_ready high again 5 cycles after accept.
- Wrap-around:
  - Stimulus: same line, start_offset=2.
  - Required: beat order words 2,3,0,1; addresses 0x1238, 0x123C, 0x1230, 0x1234; beat_last on word 1.
- Partial strobe:
  - Stimulus: strb=16'h0F30.
  - Required: beat_strb 0, 3, F, 0 for words 0..3; zero-strobe beats still issued; exactly 4 transfers.
- Backpressure:
  - Stimulus: beat_ready toggles 0,0,1,0,1,1,0,1.
  - Required: outputs stable while ready=0; each word transferred exactly once, in order; line_ready stays low throughout.
- Input change and reset mid-line:
  - Stimulus: alter line_data/line_valid during SEND.
  - Required: beats unchanged.
  - Stimulus: assert rst after 2 beats.
  - Required: beat_valid=0 in the next cycle; no further beats; a new line accepted after reset yields its own 4 beats correctly.
